// File: rtl/uart_word_decoder_pkg.sv
// rtl/uart_word_decoder_pkg.sv - shared constants, helpers and FSM encoding for the UART word decoder
package uart_word_decoder_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Each UART byte carries one terminal flag and BYTE_WIDTH-1 payload bits.
  function automatic int chunk_bits(input int byte_width);
    return byte_width - 1;
  endfunction

  function automatic int num_chunks(input int byte_width, input int word_width);
    return ceil_div(word_width, byte_width - 1);
  endfunction

  function automatic int slot_bits(input int byte_width, input int word_width);
    return (num_chunks(byte_width, word_width) - 1) * (byte_width - 1);
  endfunction

  localparam int DEF_BYTE_WIDTH = 8;
  localparam int DEF_WORD_WIDTH = 13;
  localparam int DEF_C          = chunk_bits(DEF_BYTE_WIDTH);
  localparam int DEF_NBYTES     = num_chunks(DEF_BYTE_WIDTH, DEF_WORD_WIDTH);
  localparam int DEF_SLOT_W     = slot_bits(DEF_BYTE_WIDTH, DEF_WORD_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_word_decoder_timeout.sv
// rtl/uart_word_decoder_timeout.sv - inter-byte silence counter that aborts a partial word
module uart_word_timeout
  import uart_word_decoder_pkg::*;
#(
  parameter int TIMEOUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] tcnt;

  // A clear (byte capture) in the expiry cycle takes priority over the abort.
  assign expire = enable && !clear && (tcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      tcnt <= '0;
    end else if (enable) begin
      tcnt <= tcnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_word_decoder.sv
// rtl/uart_word_decoder.sv - drains the UART RX FIFO and reassembles flag-framed multi-byte signed words
module uart_word_decoder
  import uart_word_decoder_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 13,
  parameter int TIMEOUT    = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_rdy,
  input  logic [BYTE_WIDTH-1:0]        din,
  output logic                         unload,
  output logic signed [WORD_WIDTH-1:0] dout,
  output logic                         word_valid,
  output logic                         err_short,
  output logic                         err_long,
  output logic                         err_timeout,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int C      = chunk_bits(BYTE_WIDTH);
  localparam int NBYTES = num_chunks(BYTE_WIDTH, WORD_WIDTH);
  localparam int SLOT_W = slot_bits(BYTE_WIDTH, WORD_WIDTH);
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_t            state, state_next;
  logic              capture;
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slots;
  logic [C-1:0]      chunk;
  logic              terminal;
  logic              tmo_expire;
  logic              ev_word, ev_short, ev_long, ev_timeout;

  assign chunk    = din[C-1:0];
  assign terminal = din[BYTE_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // byte_rdy seen in CAPTURE already reflects the read, so an emptying FIFO is not over-read.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (byte_rdy) state_next = ST_READ;
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = byte_rdy ? ST_READ : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    unload  = (state == ST_READ);
    capture = (state == ST_CAPTURE);
  end

  always_comb begin
    ev_word    = 1'b0;
    ev_short   = 1'b0;
    ev_long    = 1'b0;
    ev_timeout = 1'b0;
    if (capture) begin
      if (terminal) begin
        if (cnt == LAST) ev_word  = 1'b1;
        else             ev_short = 1'b1;
      end else if (cnt == LAST) begin
        ev_long = 1'b1;
      end
    end else if (tmo_expire) begin
      ev_timeout = 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      uart_word_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (capture),
        .enable (cnt != '0),
        .expire (tmo_expire)
      );
    end else begin : g_no_tmo
      assign tmo_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      slots       <= '0;
      dout        <= '0;
      word_valid  <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      word_valid  <= ev_word;
      err_short   <= ev_short;
      err_long    <= ev_long;
      err_timeout <= ev_timeout;
      // Chunks arrive LSB first; the terminal chunk supplies the sign bit.
      if (ev_word) dout <= $signed(WORD_WIDTH'({chunk, slots}));
      if (capture) begin
        if (terminal) begin
          cnt <= '0;
        end else if (ev_long) begin
          slots[C-1:0] <= chunk;
          cnt          <= CNT_W'(1);
        end else begin
          slots[int'(cnt)*C +: C] <= chunk;
          cnt                     <= cnt + CNT_W'(1);
        end
      end else if (ev_timeout) begin
        cnt <= '0;
      end
      if ((ev_short || ev_long || ev_timeout) && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: doc/uart_word_decoder.md
# uart_word_decoder

Parametrised successor to the single-edge UART unload logic. It drains bytes from the UART receive FIFO with a read strobe and reassembles multi-byte words of arbitrary WORD_WIDTH from a flag-framed byte stream. It reports framing errors and inter-byte timeouts. It sits between the UART receiver FIFO and the command/DAC-setpoint registers.

## Interface
- BYTE_WIDTH, 8: UART byte width; MSB is the terminal flag, C = BYTE_WIDTH-1 payload bits per byte.
- WORD_WIDTH, 13: assembled signed word width; NBYTES = ceil(WORD_WIDTH/C), NBYTES ≥ 2.
- TIMEOUT, 0: clk cycles of inter-byte silence that abort a partial word; 0 disables.
- ERR_CNT_W, 8: width of the saturating error counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- byte_rdy  in  1  FIFO not-empty, level.
- din  in  BYTE_WIDTH  FIFO read data, valid the cycle after unload.
- unload  out  1  FIFO read strobe, one-cycle pulse.
- dout  out  WORD_WIDTH (signed)  last assembled word, held until the next word.
- word_valid  out  1  one-cycle pulse; dout updated the same cycle.
- err_short  out  1  pulse: terminal byte arrived with fewer than NBYTES-1 preceding bytes.
- err_long  out  1  pulse: a non-terminal byte arrived when NBYTES-1 were already stored.
- err_timeout  out  1  pulse: partial word aborted by timeout.
- err_count  out  ERR_CNT_W  saturating count of all error pulses.

## Operation
- FSM has three states.
  - IDLE: if byte_rdy, go to READ.
  - READ: unload=1, go to CAPTURE.
  - CAPTURE: sample din and process it. If byte_rdy, go to READ; otherwise go to IDLE.
- Processing a byte with din[BYTE_WIDTH-1]=0 (non-terminal), where cnt is the number of stored chunks:
  - cnt < NBYTES-1: store din[C-1:0] at chunk slot cnt; cnt++.
  - cnt = NBYTES-1: err_long; discard stored chunks; store this chunk in slot 0; cnt=1.
- Processing a byte with din[BYTE_WIDTH-1]=1 (terminal):
  - cnt = NBYTES-1: dout = low WORD_WIDTH bits of {din[C-1:0], slot[NBYTES-2], …, slot[0]}; word_valid=1.
  - cnt ≠ NBYTES-1: err_short; no dout change.
  - In both cases cnt=0.
- Chunks arrive LSB first. Terminal-byte payload bits above WORD_WIDTH are ignored. dout is two's complement, with its MSB taken from the terminal chunk.
- Timeout (TIMEOUT>0):
  - The counter clears on every CAPTURE and increments while cnt≠0.
  - When it reaches TIMEOUT: err_timeout, cnt=0, counter clears.
  - A CAPTURE in the same cycle as expiry wins; no timeout fires.
- err_count increments by 1 per cycle in which any error pulses and saturates at all-ones. Error pulses are mutually exclusive by construction.

## Timing
- Reset values: unload 0, dout 0, word_valid 0, all err_* 0, err_count 0, state IDLE, cnt 0, timeout counter 0.
- Latency:
  - byte_rdy high in cycle n gives unload in n+1 and capture in n+2.
  - word_valid/errors register in n+3 (one cycle after capture).
- Throughput: one byte per 2 cycles while byte_rdy stays high.
- byte_rdy sampled in CAPTURE reflects the FIFO after the read, so no extra read is issued on an emptying FIFO.
- Reset mid-operation: a byte already strobed by unload but not captured is lost. The partial word is discarded and no error pulses.
- dout holds between words; word_valid is the only qualifier.

## Structure
- Shared package holds:
  - the derived constants C, NBYTES and SLOT_W = (NBYTES-1)*C;
  - a function ceil_div;
  - the FSM state encoding (IDLE/READ/CAPTURE).
- Single sub-module uart_word_timeout: timeout counter with clear/enable/expire. It is instantiated only when TIMEOUT>0 (generate); otherwise expire is tied to 0.
- The top-level holds the FSM, chunk store, assembly and error counter.

## Test plan
- Defaults (8/13), bytes 0x55, 0x9A back-to-back with byte_rdy held high → unload every 2nd cycle; dout=0x0D55 (+3413); one word_valid; no errors.
- Defaults, bytes 0x00, 0xA0 → dout=0x1000 (-4096); then 0x7F, 0xFF → dout=0x1FFF (-1).
- Defaults:
  - byte 0x80 alone → err_short, err_count=1, no word_valid, dout unchanged.
  - Then bytes 0x11, 0x22, 0x83 → err_long on 0x22; dout=0x01A2; err_count=2.
- TIMEOUT=100, byte 0x11 then 100 idle cycles → err_timeout exactly 100 cycles after capture. Then byte 0x81 → err_short. Variant: the next byte is captured on the expiry cycle → no timeout; 0x81 completes word 0x0091.
- WORD_WIDTH=16 (NBYTES=3):
  - 0x7F, 0x7F, 0x83 → dout=0xFFFF (-1).
  - 0x00, 0x00, 0x82 → dout=0x8000.
  - err_count saturation: 300 lone 0x80 bytes with ERR_CNT_W=8 → err_count=255.
- Assert rst during CAPTURE of byte 1 of a word → all outputs return to reset values. A following clean 2-byte word decodes correctly with no error pulse.
